// File: rtl/minimac3_rxcheck_if.sv
// minimac3_rxcheck_if
//   Groups the receive-buffer snoop signals and the per-slot status outputs
//   of minimac3_rxcheck.
//   master : receive path / test driver (drives writes, done and ack strobes)
//   slave  : the checker (samples writes, drives per-slot status)
interface minimac3_rxcheck_if;
  logic [7:0]  rxb_dat;
  logic        rxb0_we;
  logic        rxb1_we;
  logic [10:0] rxb0_adr;
  logic [10:0] rxb1_adr;
  logic [1:0]  rx_done;
  logic [1:0]  status_ack;
  logic [1:0]  status_valid;
  logic [1:0]  crc_ok;
  logic [1:0]  sfd_ok;
  logic [1:0]  dribble;
  logic [1:0]  overrun;
  logic [10:0] payload_off_0;
  logic [10:0] payload_off_1;
  logic [10:0] payload_len_0;
  logic [10:0] payload_len_1;

  modport master (
    output rxb_dat, rxb0_we, rxb1_we, rxb0_adr, rxb1_adr, rx_done, status_ack,
    input  status_valid, crc_ok, sfd_ok, dribble, overrun,
           payload_off_0, payload_off_1, payload_len_0, payload_len_1
  );

  modport slave (
    input  rxb_dat, rxb0_we, rxb1_we, rxb0_adr, rxb1_adr, rx_done, status_ack,
    output status_valid, crc_ok, sfd_ok, dribble, overrun,
           payload_off_0, payload_off_1, payload_len_0, payload_len_1
  );
endinterface

// File: rtl/minimac3_rxcheck.sv
// minimac3_rxcheck
//   Receive-side frame checker. Snoops byte writes into the two receive slot
//   buffers, finds preamble/SFD, runs CRC-32 over the bytes after the SFD and
//   latches a per-slot status word on each rx_done strobe.
// Ports
//   phy_rx_clk : receive clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   bus        : minimac3_rxcheck_if.slave (write snoop in, status out)
module minimac3_rxcheck (
  input logic               phy_rx_clk,
  input logic               sys_rst_n,
  minimac3_rxcheck_if.slave bus
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_MAX     = 11'd2047;
  localparam logic [7:0]  BYTE_PRE    = 8'h55;
  localparam logic [7:0]  BYTE_SFD    = 8'hD5;

  typedef enum logic [1:0] {S_HUNT, S_PREAMBLE, S_DATA, S_BAD} state_t;

  // One full byte of reflected CRC-32, LSB first, in a single cycle.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = (r >> 1) ^ ((r[0] ^ d[b]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  function automatic logic [10:0] len_sat_inc(input logic [10:0] l);
    return (l == LEN_MAX) ? l : l + 11'd1;
  endfunction

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_crc;
  logic [10:0] r_len;
  logic [10:0] r_off;

  logic        w_we;
  logic [10:0] w_adr;
  logic        w_done;
  logic [1:0]  w_lat;
  logic        w_in_data;
  logic        w_sfd_hit;
  logic [31:0] w_crc_nx;
  logic [10:0] w_len_nx;
  logic        w_crc_ok;

  logic [1:0]       r_valid;
  logic [1:0]       r_crc_ok;
  logic [1:0]       r_sfd_ok;
  logic [1:0]       r_dribble;
  logic [1:0]       r_overrun;
  logic [1:0][10:0] r_poff;
  logic [1:0][10:0] r_plen;

  assign w_we   = bus.rxb0_we | bus.rxb1_we;
  assign w_adr  = bus.rxb0_we ? bus.rxb0_adr : bus.rxb1_adr;
  assign w_done = |bus.rx_done;
  // Slot 0 wins if both done bits are ever seen together.
  assign w_lat  = {bus.rx_done[1] & ~bus.rx_done[0], bus.rx_done[0]};

  // State register
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_HUNT;
    else            r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    if (w_done) begin
      w_state_nx = S_HUNT;
    end else if (w_we) begin
      case (r_state)
        S_HUNT:     w_state_nx = (bus.rxb_dat == BYTE_PRE) ? S_PREAMBLE : S_BAD;
        S_PREAMBLE: begin
          if (bus.rxb_dat == BYTE_SFD)      w_state_nx = S_DATA;
          else if (bus.rxb_dat != BYTE_PRE) w_state_nx = S_BAD;
        end
        default:    w_state_nx = r_state;
      endcase
    end
  end

  // State decode
  always_comb begin
    w_in_data = 1'b0;
    w_sfd_hit = 1'b0;
    case (r_state)
      S_DATA:     w_in_data = 1'b1;
      S_PREAMBLE: w_sfd_hit = w_we && (bus.rxb_dat == BYTE_SFD);
      default:    ;
    endcase
  end

  // Next CRC/length include a write that lands in the same cycle as rx_done.
  assign w_crc_nx = (w_in_data && w_we) ? crc_byte(r_crc, bus.rxb_dat) : r_crc;
  assign w_len_nx = (w_in_data && w_we) ? len_sat_inc(r_len) : r_len;
  assign w_crc_ok = w_in_data && (w_len_nx >= 11'd4) && (w_crc_nx == CRC_RESIDUE);

  // Core accumulators
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_crc <= CRC_INIT;
      r_len <= '0;
      r_off <= '0;
    end else if (w_done) begin
      r_crc <= CRC_INIT;
      r_len <= '0;
    end else if (w_sfd_hit) begin
      r_off <= w_adr + 11'd1;
      r_crc <= CRC_INIT;
      r_len <= '0;
    end else begin
      r_crc <= w_crc_nx;
      r_len <= w_len_nx;
    end
  end

  // Per-slot status; a done in the same cycle as ack keeps the slot valid.
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_valid   <= '0;
      r_crc_ok  <= '0;
      r_sfd_ok  <= '0;
      r_dribble <= '0;
      r_overrun <= '0;
      r_poff    <= '0;
      r_plen    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_lat[i]) begin
          r_valid[i]   <= 1'b1;
          r_overrun[i] <= r_valid[i] & ~bus.status_ack[i];
          r_sfd_ok[i]  <= w_in_data;
          r_crc_ok[i]  <= w_crc_ok;
          r_dribble[i] <= ~w_we;
          r_poff[i]    <= w_in_data ? r_off : 11'd0;
          r_plen[i]    <= w_in_data ? w_len_nx : 11'd0;
        end else if (bus.status_ack[i]) begin
          r_valid[i]   <= 1'b0;
          r_overrun[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.status_valid  = r_valid;
  assign bus.crc_ok        = r_crc_ok;
  assign bus.sfd_ok        = r_sfd_ok;
  assign bus.dribble       = r_dribble;
  assign bus.overrun       = r_overrun;
  assign bus.payload_off_0 = r_poff[0];
  assign bus.payload_off_1 = r_poff[1];
  assign bus.payload_len_0 = r_plen[0];
  assign bus.payload_len_1 = r_plen[1];

endmodule

// File: tb/tb_minimac3_rxcheck.sv
module tb_minimac3_rxcheck;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  minimac3_rxcheck_if ifc();

  minimac3_rxcheck dut (
    .phy_rx_clk (clk),
    .sys_rst_n  (rst_n),
    .bus        (ifc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: bytes of the frame in progress and per-slot status.
  logic [7:0]  q_dat[$];
  logic [10:0] q_adr[$];
  bit m_valid[2], m_ovr[2], m_crc[2], m_sfd[2], m_drib[2];
  int m_off[2], m_len[2];

  typedef struct {
    int slot; int base; int npre; bit sfd; int nbody; bit fcs; int corrupt; bit late;
    bit e_crc; bit e_sfd; bit e_drib; int e_off; int e_len;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Frame interpretation: leading run of 0x55, then 0xD5, then body+FCS.
  task automatic model_frame(output bit sfd, output bit ok, output int off, output int len);
    int n, i, s;
    logic [31:0] c, fcs;
    n = q_dat.size(); sfd = 0; ok = 0; off = 0; len = 0; i = 0;
    if (n > 0 && q_dat[0] == 8'h55) begin
      while (i < n && q_dat[i] == 8'h55) i++;
      if (i < n && q_dat[i] == 8'hD5) begin
        sfd = 1;
        off = (int'(q_adr[i]) + 1) % 2048;
        s = i + 1;
        len = (n - s > 2047) ? 2047 : n - s;
        if (n - s >= 4) begin
          c = 32'hFFFFFFFF;
          for (int k = s; k < n - 4; k++) c = crc_step(c, q_dat[k]);
          c = ~c;
          fcs = {q_dat[n-1], q_dat[n-2], q_dat[n-3], q_dat[n-4]};
          ok = (c == fcs);
        end
      end
    end
  endtask

  task automatic model_reset();
    q_dat.delete(); q_adr.delete();
    for (int s = 0; s < 2; s++) begin
      m_valid[s] = 0; m_ovr[s] = 0; m_crc[s] = 0; m_sfd[s] = 0; m_drib[s] = 0;
      m_off[s] = 0; m_len[s] = 0;
    end
  endtask

  task automatic cyc(input bit we, input int slot, input logic [10:0] adr, input logic [7:0] dat,
                     input logic [1:0] done, input logic [1:0] ack);
    bit sfd, ok; int off, len, lat;
    ifc.rxb_dat    = dat;
    ifc.rxb0_we    = we && slot == 0;
    ifc.rxb1_we    = we && slot == 1;
    ifc.rxb0_adr   = (slot == 0) ? adr : 11'($urandom);
    ifc.rxb1_adr   = (slot == 1) ? adr : 11'($urandom);
    ifc.rx_done    = done;
    ifc.status_ack = ack;
    @(posedge clk);
    if (we) begin q_dat.push_back(dat); q_adr.push_back(adr); end
    lat = done[0] ? 0 : (done[1] ? 1 : -1);
    sfd = 0; ok = 0; off = 0; len = 0;
    if (lat >= 0) model_frame(sfd, ok, off, len);
    for (int s = 0; s < 2; s++) begin
      if (s == lat) begin
        m_ovr[s] = m_valid[s] && !ack[s];
        m_valid[s] = 1; m_sfd[s] = sfd; m_crc[s] = ok; m_drib[s] = !we;
        m_off[s] = off; m_len[s] = len;
      end else if (ack[s]) begin
        m_valid[s] = 0; m_ovr[s] = 0;
      end
    end
    if (done != 2'b00) begin q_dat.delete(); q_adr.delete(); end
    #1;
    ifc.rxb0_we = 0; ifc.rxb1_we = 0; ifc.rx_done = 0; ifc.status_ack = 0;
  endtask

  task automatic send_frame(input int slot, input int base, input int npre, input bit sfd,
                            input int nbody, input bit fcs, input int corrupt, input bit late,
                            input bit ack_done, input int garble);
    logic [7:0] fr[$];
    logic [31:0] c;
    logic [7:0] b;
    logic [1:0] m;
    int n, hdr;
    bit last;
    m = (slot == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < npre; i++) fr.push_back(8'h55);
    if (sfd) fr.push_back(8'hD5);
    hdr = fr.size();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nbody; i++) begin
      b = 8'($urandom); fr.push_back(b); c = crc_step(c, b);
    end
    c = ~c;
    if (fcs) for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    if (corrupt >= 0 && hdr + corrupt < fr.size()) fr[hdr+corrupt] = fr[hdr+corrupt] ^ 8'h01;
    if (garble >= 0 && garble < fr.size()) fr[garble] = 8'($urandom);
    n = fr.size();
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      cyc(1'b1, slot, 11'(base + i), fr[i], (last && !late) ? m : 2'b00,
          (last && !late && ack_done) ? m : 2'b00);
      if (!last) cyc(1'b0, slot, 11'd0, 8'($urandom), 2'b00, 2'b00);
    end
    if (late || n == 0) cyc(1'b0, slot, 11'd0, 8'd0, m, ack_done ? m : 2'b00);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic logic [10:0] got_off(input int s);
    return (s == 0) ? ifc.payload_off_0 : ifc.payload_off_1;
  endfunction
  function automatic logic [10:0] got_len(input int s);
    return (s == 0) ? ifc.payload_len_0 : ifc.payload_len_1;
  endfunction

  task automatic check_exp(input string tag, input int s, input bit v, input bit ovr, input bit sfd,
                           input bit crc, input bit drib, input int off, input int len);
    chk($sformatf("%s valid[%0d]", tag, s),   ifc.status_valid[s], v);
    chk($sformatf("%s overrun[%0d]", tag, s), ifc.overrun[s], ovr);
    chk($sformatf("%s sfd_ok[%0d]", tag, s),  ifc.sfd_ok[s], sfd);
    chk($sformatf("%s crc_ok[%0d]", tag, s),  ifc.crc_ok[s], crc);
    chk($sformatf("%s dribble[%0d]", tag, s), ifc.dribble[s], drib);
    chk($sformatf("%s off[%0d]", tag, s),     got_off(s), off);
    chk($sformatf("%s len[%0d]", tag, s),     got_len(s), len);
  endtask

  task automatic check_model(input string tag, input int s);
    check_exp(tag, s, m_valid[s], m_ovr[s], m_sfd[s], m_crc[s], m_drib[s], m_off[s], m_len[s]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " status_valid"}, ifc.status_valid, 0);
    chk({tag, " crc_ok"},       ifc.crc_ok, 0);
    chk({tag, " sfd_ok"},       ifc.sfd_ok, 0);
    chk({tag, " dribble"},      ifc.dribble, 0);
    chk({tag, " overrun"},      ifc.overrun, 0);
    chk({tag, " off0"},         ifc.payload_off_0, 0);
    chk({tag, " off1"},         ifc.payload_off_1, 0);
    chk({tag, " len0"},         ifc.payload_len_0, 0);
    chk({tag, " len1"},         ifc.payload_len_1, 0);
  endtask

  initial begin
    int r_slot, r_base, r_npre, r_nbody, r_corrupt, r_garble;
    bit r_sfd, r_fcs, r_late, r_ack;

    //          slot base npre sfd nbody fcs corr late | crc sfd drib off len
    tbl[0] = '{0,    0,   7,   1,  60,   1,  -1,  0,    1,  1,  0,   8,  64};
    tbl[1] = '{1,    0,   7,   1,  60,   1,  10,  0,    0,  1,  0,   8,  64};
    tbl[2] = '{0,    0,   20,  0,  0,    0,  -1,  0,    0,  0,  0,   0,  0};
    tbl[3] = '{0,    0,   7,   1,  60,   1,  -1,  1,    1,  1,  1,   8,  64};
    tbl[4] = '{1,    5,   2,   1,  3,    0,  -1,  0,    0,  1,  0,   8,  3};
    tbl[5] = '{1,    2040,7,   1,  20,   1,  -1,  0,    1,  1,  0,   0,  24};
    tbl[6] = '{0,    0,   0,   1,  10,   1,  -1,  0,    0,  0,  0,   0,  0};

    ifc.rxb_dat = 0; ifc.rxb0_we = 0; ifc.rxb1_we = 0; ifc.rxb0_adr = 0; ifc.rxb1_adr = 0;
    ifc.rx_done = 0; ifc.status_ack = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) begin
      cyc(1'b0, 0, 11'd0, 8'd0, 2'b00, 2'b11);
      send_frame(tbl[t].slot, tbl[t].base, tbl[t].npre, tbl[t].sfd, tbl[t].nbody, tbl[t].fcs,
                 tbl[t].corrupt, tbl[t].late, 1'b0, -1);
      check_exp($sformatf("vec%0d", t), tbl[t].slot, 1'b1, 1'b0, tbl[t].e_sfd, tbl[t].e_crc,
                tbl[t].e_drib, tbl[t].e_off, tbl[t].e_len);
      chk($sformatf("vec%0d other valid", t), ifc.status_valid[1 - tbl[t].slot], 0);
    end

    // Overwrite without ack, then ack colliding with a new done.
    cyc(1'b0, 0, 11'd0, 8'd0, 2'b00, 2'b11);
    send_frame(0, 0, 7, 1'b1, 60, 1'b1, -1, 1'b0, 1'b0, -1);
    send_frame(0, 100, 7, 1'b1, 30, 1'b1, -1, 1'b0, 1'b0, -1);
    check_exp("overwrite", 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 108, 34);
    send_frame(0, 0, 7, 1'b1, 60, 1'b1, -1, 1'b0, 1'b1, -1);
    check_exp("ack+done", 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8, 64);
    cyc(1'b0, 0, 11'd0, 8'd0, 2'b00, 2'b01);
    check_exp("ack hold", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8, 64);

    // Randomized frames against the reference model.
    for (int f = 0; f < 60; f++) begin
      r_slot    = int'($urandom_range(0, 1));
      r_base    = int'($urandom_range(0, 2047));
      r_npre    = int'($urandom_range(0, 8));
      r_sfd     = ($urandom_range(0, 7) != 0);
      r_nbody   = int'($urandom_range(0, 40));
      r_fcs     = ($urandom_range(0, 3) != 0);
      r_corrupt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      r_late    = ($urandom_range(0, 1) == 1);
      r_ack     = ($urandom_range(0, 1) == 1);
      r_garble  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
      send_frame(r_slot, r_base, r_npre, r_sfd, r_nbody, r_fcs, r_corrupt, r_late, r_ack, r_garble);
      check_model($sformatf("rnd%0d", f), 0);
      check_model($sformatf("rnd%0d", f), 1);
      if ($urandom_range(0, 2) == 0) begin
        cyc(1'b0, 0, 11'd0, 8'd0, 2'b00, 2'($urandom));
        check_model($sformatf("rnd%0d ack", f), 0);
        check_model($sformatf("rnd%0d ack", f), 1);
      end
    end

    // Reset in the middle of a payload, then a clean frame.
    send_frame(1, 0, 7, 1'b1, 20, 1'b1, -1, 1'b0, 1'b0, -1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 0, 11'(i), 8'h55, 2'b00, 2'b00);
    cyc(1'b1, 0, 11'd7, 8'hD5, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 0, 11'(8 + i), 8'($urandom), 2'b00, 2'b00);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("midreset");
    @(posedge clk); #1;
    check_zero("midreset held");
    #2 rst_n = 1'b1;
    send_frame(0, 0, 7, 1'b1, 60, 1'b1, -1, 1'b0, 1'b0, -1);
    check_exp("after reset", 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8, 64);
    chk("after reset valid[1]", ifc.status_valid[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
